// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared state encoding and widths for the skid pipeline stage
package pipe_pkg;

   localparam int PIPE_OCC_W = 2;

   // The encoding is also the entry count, so occupancy is the state itself.
   typedef enum logic [PIPE_OCC_W-1:0] {
      EMPTY = 2'd0,
      BUSY  = 2'd1,
      FULL  = 2'd2
   } skid_state_t;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter with priority clear
module sat_counter #(
   parameter int W = 16
) (
   input  logic         CLK,
   input  logic         nRST,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] count
);

   logic [W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clr)
         count_d = '0;
      else if (inc && (count_q != {W{1'b1}}))
         count_d = count_q + 1'b1;
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST)
         count_q <= '0;
      else
         count_q <= count_d;
   end

   assign count = count_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - valid/ready pipeline register with two-entry skid buffer
module pipe_stage_skid
   import pipe_pkg::*;
#(
   parameter int DATA_W         = 64,
   parameter bit CLEAR_ON_FLUSH = 1'b1,
   parameter int STALL_CNT_W    = 16
) (
   input  logic                   CLK,
   input  logic                   nRST,
   input  logic                   flush,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [DATA_W-1:0]      in_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [DATA_W-1:0]      out_data,
   output logic [PIPE_OCC_W-1:0]  occupancy,
   output logic [STALL_CNT_W-1:0] stall_cnt,
   input  logic                   stall_clr
);

   skid_state_t       state_q, state_d;
   logic [DATA_W-1:0] main_q, main_d;
   logic [DATA_W-1:0] skid_q, skid_d;
   logic              in_ready_q, in_ready_d;
   logic              acc_in, acc_out;

   assign acc_in  = in_valid & in_ready_q;
   assign acc_out = out_valid & out_ready;

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush) begin
         state_d = EMPTY;
         if (CLEAR_ON_FLUSH) begin
            main_d = '0;
            skid_d = '0;
         end
      end else begin
         unique case (state_q)
            EMPTY: begin
               if (acc_in) begin
                  main_d  = in_data;
                  state_d = BUSY;
               end
            end
            BUSY: begin
               if (acc_in && acc_out) begin
                  main_d = in_data;
               end else if (acc_in) begin
                  skid_d  = in_data;
                  state_d = FULL;
               end else if (acc_out) begin
                  state_d = EMPTY;
               end
            end
            FULL: begin
               // in_ready is low here, so only the drain path is live.
               if (acc_out) begin
                  main_d  = skid_q;
                  state_d = BUSY;
               end
            end
            default: state_d = EMPTY;
         endcase
      end
      in_ready_d = (state_d != FULL);
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q    <= EMPTY;
         main_q     <= '0;
         skid_q     <= '0;
         in_ready_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         main_q     <= main_d;
         skid_q     <= skid_d;
         in_ready_q <= in_ready_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = (state_q != EMPTY);
   assign out_data  = main_q;
   assign occupancy = state_q;

   sat_counter #(
      .W(STALL_CNT_W)
   ) u_stall_cnt (
      .CLK  (CLK),
      .nRST (nRST),
      .inc  (out_valid & ~out_ready & ~flush),
      .clr  (stall_clr),
      .count(stall_cnt)
   );

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
Parametrised pipeline-stage register with a valid/ready handshake, replacing the fixed-field, enable-only inter-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB) with one reusable block. The payload is a packed vector, so any stage's control and data fields go through the same RTL. The block adds a two-entry skid buffer so that `in_ready` is fully registered. It also provides a synchronous flush for branch/jump squash and a saturating stall-cycle counter for performance debug.

Parameters:
- DATA_W, 64: width of the packed stage payload in bits (must be ≥ 1).
- CLEAR_ON_FLUSH, 1: 1 = flush also zeroes both data registers; 0 = flush clears valid state only.
- STALL_CNT_W, 16: width of the saturating stall-cycle counter.

Ports:
- CLK  in  1  clock, all state updates on rising edge.
- nRST  in  1  asynchronous active-low reset.
- flush  in  1  synchronous squash of all held entries.
- in_valid  in  1  upstream payload valid.
- in_ready  out  1  block can accept a payload this cycle (registered).
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  `out_data` holds a valid payload.
- out_ready  in  1  downstream accepts `out_data` this cycle.
- out_data  out  DATA_W  head payload (registered).
- occupancy  out  2  number of held entries, 0..2.
- stall_cnt  out  STALL_CNT_W  cycles with `out_valid`=1 and `out_ready`=0, saturating.
- stall_clr  in  1  synchronous clear of `stall_cnt`.

Behaviour:
- **Reset.** Reset is asynchronous, active-low, on `nRST`; all state is cleared immediately and held while `nRST`=0. Reset values:
  - `out_valid`=0, `out_data`=0, skid data=0
  - `in_ready`=1, `occupancy`=0, `stall_cnt`=0
  - state=EMPTY
- **Storage.** Two registers: `main` drives `out_data`; `skid` holds the overflow entry.
- **Handshakes.** `acc_in` = `in_valid` & `in_ready`; `acc_out` = `out_valid` & `out_ready`.
- **States** (encoded in the package): EMPTY (occ 0), BUSY (occ 1), FULL (occ 2).
- **Transitions** (when `flush`=0):
  - EMPTY: `acc_in` → `main`←`in_data`, go to BUSY. Otherwise stay.
  - BUSY, `acc_in` & `acc_out`: `main`←`in_data`, stay in BUSY.
  - BUSY, `acc_in` only: `skid`←`in_data`, go to FULL.
  - BUSY, `acc_out` only: go to EMPTY.
  - BUSY, neither: hold.
  - FULL: `in_ready`=0, so no input is accepted. `acc_out` → `main`←`skid`, go to BUSY. Otherwise hold.
- **Derived outputs.**
  - `in_ready` is registered and equals (next state != FULL).
  - `out_valid` = (state != EMPTY).
  - `occupancy` = state encoding.
- **Latency and throughput.** An input accepted in cycle N appears on `out_data` with `out_valid`=1 in cycle N+1 when the block was EMPTY. Sustained throughput is 1 payload per cycle when `out_ready` stays high.
- **Ordering.** Payloads leave strictly in acceptance order; none are dropped or duplicated.
- **Flush.**
  - `flush`=1 has priority over every handshake: next state is EMPTY, `in_valid` that cycle is ignored, and next `in_ready`=1.
  - A payload presented downstream in the flush cycle still counts as consumed if `out_ready`=1. It is gone either way.
  - When CLEAR_ON_FLUSH=1, `main` and `skid` are zeroed.
- **Stall counter.**
  - Increments when `out_valid` & !`out_ready` & !`flush`.
  - Saturates at all-ones and never wraps.
  - `stall_clr` has priority over increment: value becomes 0 next cycle.
- **Data hold.** While not loading, `main` and `skid` hold their value; there are no spurious updates.
- **Reset mid-operation.** Held entries are discarded and the block returns to EMPTY with `in_ready`=1.
- **Width rule.** `out_data` is bit-exact with `in_data`; there is no sign or zero extension.

Decomposition:
- Package `pipe_pkg`:
  - typedef enum logic [1:0] `skid_state_t` {EMPTY=0, BUSY=1, FULL=2}.
  - Constant `PIPE_OCC_W`=2.
- Stage payload structs (e.g. the ID/EX control bundle) live in `cpu_types_pkg` and are cast to DATA_W at instantiation.
- Sub-module `sat_counter` (params W; ports CLK, nRST, inc, clr, count) implements `stall_cnt`. It is reusable by other performance counters.

Test Plan:
- **Reset.** Hold `nRST`=0 mid-stream with occ=2 → same cycle: `out_valid`=0, `out_data`=0, `in_ready`=1, `occupancy`=0; after release, the first accepted payload is 0xA5 and appears on the next cycle.
- **Streaming.** `in_valid`=1, `out_ready`=1, data 1,2,3,…,10 on consecutive cycles → `out_data` 1..10 one cycle later each, `in_ready` never drops, `stall_cnt`=0.
- **Backpressure/skid.** Send 0x11, 0x22, 0x33 back-to-back with `out_ready`=0:
  - occ goes 1 then 2 and `in_ready` falls after 0x22 is accepted.
  - 0x33 is held upstream and not accepted.
  - After `out_ready`=1: outputs 0x11, 0x22, 0x33 in order.
  - `stall_cnt` equals the number of stalled cycles.
- **Flush priority.** occ=2 (0x44, 0x55), assert `flush` together with `in_valid` (0x66) → next cycle occ=0, `out_valid`=0, data regs 0 (CLEAR_ON_FLUSH=1); 0x66 is never output.
- **Stall counter.** STALL_CNT_W=4, hold `out_valid`=1 with `out_ready`=0 for 20 cycles → `stall_cnt` saturates at 15. Assert `stall_clr` together with a stall → 0 next cycle.
- **Random.** Randomised `in_valid`/`out_ready`/`flush` checked against a 2-deep reference queue → no loss, duplication or reordering; `occupancy` always matches the model.
